// File: rtl/mem_arbiter_if.sv
// Unified memory bus between the arbiter and the memory.
//   m_req   : request, held until m_ack
//   m_we    : 1 = write, 0 = read
//   m_addr  : word-aligned byte address
//   m_mask  : byte enables (all ones for reads)
//   m_wdata : write data
//   m_ack   : one-cycle completion strobe
//   m_rdata : read data, valid in the m_ack cycle
// The arbiter uses the master modport; the memory uses the slave modport.
interface mem_arbiter_if;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [3:0]  m_mask;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;

  modport master (
    output m_req, m_we, m_addr, m_mask, m_wdata,
    input  m_ack, m_rdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_mask, m_wdata,
    output m_ack, m_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port to one-port memory arbiter: an instruction fetch port and a data
// load/store port share a single memory bus, one transaction at a time.
// Data normally wins contention; after STARVE_LIMIT consecutive data grants
// taken while a fetch was waiting, the fetch is granted.
//   clk, reset              : clock, synchronous active-high reset
//   i_req/i_addr            : fetch request (level) and byte address
//   i_valid/i_rdata         : one-cycle fetch completion and registered word
//   d_rd/d_wr/d_addr/d_mask/d_wdata : load/store request (level) and payload
//   d_valid/d_rdata         : one-cycle data completion and registered load word
//   mem                     : unified memory bus (master side)
//   busy                    : high whenever the FSM is not in IDLE
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [31:0]          i_addr,
  output logic                 i_valid,
  output logic [31:0]          i_rdata,
  input  logic                 d_rd,
  input  logic                 d_wr,
  input  logic [31:0]          d_addr,
  input  logic [3:0]           d_mask,
  input  logic [31:0]          d_wdata,
  output logic                 d_valid,
  output logic [31:0]          d_rdata,
  mem_arbiter_if.master        mem,
  output logic                 busy
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] starve_cnt;
  logic          resp_is_i;   // which requester the RESP cycle answers
  logic          grant_i, grant_d;

  logic          m_req_q, m_we_q;
  logic [31:0]   m_addr_q, m_wdata_q;
  logic [3:0]    m_mask_q;

  // Byte-offset bits are dropped: the memory only sees word addresses.
  logic          unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

  assign mem.m_req   = m_req_q;
  assign mem.m_we    = m_we_q;
  assign mem.m_addr  = m_addr_q;
  assign mem.m_mask  = m_mask_q;
  assign mem.m_wdata = m_wdata_q;

  // Grant decision, only meaningful in IDLE.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state_q == IDLE) begin
      grant_d = (d_rd | d_wr) && (!i_req || (starve_cnt < LIMIT));
      grant_i = i_req && !grant_d;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if      (grant_i) state_d = BUSY_I;
        else if (grant_d) state_d = BUSY_D;
      end
      BUSY_I, BUSY_D: if (mem.m_ack) state_d = RESP;
      RESP:           state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  // Output decode: completion pulses come straight from the RESP state.
  always_comb begin
    busy    = (state_q != IDLE);
    i_valid = 1'b0;
    d_valid = 1'b0;
    if (state_q == RESP) begin
      i_valid = resp_is_i;
      d_valid = !resp_is_i;
    end
  end

  // Bus request registers, starvation counter and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_mask_q   <= '0;
      m_wdata_q  <= '0;
      starve_cnt <= '0;
      resp_is_i  <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      if (grant_i) begin
        m_req_q    <= 1'b1;
        m_we_q     <= 1'b0;
        m_addr_q   <= {i_addr[31:2], 2'b00};
        m_mask_q   <= 4'b1111;
        resp_is_i  <= 1'b1;
        starve_cnt <= '0;
      end else if (grant_d) begin
        // A simultaneous d_rd is ignored: d_wr makes it a store.
        m_req_q    <= 1'b1;
        m_we_q     <= d_wr;
        m_addr_q   <= {d_addr[31:2], 2'b00};
        m_mask_q   <= d_wr ? d_mask : 4'b1111;
        m_wdata_q  <= d_wdata;
        resp_is_i  <= 1'b0;
        if (i_req && (starve_cnt != LIMIT)) starve_cnt <= starve_cnt + 1'b1;
      end

      // m_ack outside BUSY_x is ignored.
      if (mem.m_ack && (state_q == BUSY_I || state_q == BUSY_D)) begin
        m_req_q <= 1'b0;
        if (state_q == BUSY_I) i_rdata <= mem.m_rdata;
        else if (!m_we_q)      d_rdata <= mem.m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Expected bus transactions and
// completions are queued when requests are issued; a memory responder pops
// and checks bus transactions, the service loop pops and checks completions.
module tb_mem_arbiter;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_valid;
  logic [31:0] i_addr, i_rdata;
  logic        d_rd, d_wr, d_valid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_mask;
  logic        busy;

  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_valid (i_valid),
    .i_rdata (i_rdata),
    .d_rd    (d_rd),
    .d_wr    (d_wr),
    .d_addr  (d_addr),
    .d_mask  (d_mask),
    .d_wdata (d_wdata),
    .d_valid (d_valid),
    .d_rdata (d_rdata),
    .mem     (bus),
    .busy    (busy)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rdata;   // what the memory returns
  } mem_exp_t;

  typedef struct packed {
    logic        is_i;
    logic [31:0] i_rdata;
    logic [31:0] d_rdata;
  } resp_exp_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } dreq_t;

  mem_exp_t  exp_mem[$];
  resp_exp_t exp_resp[$];
  dreq_t     dq[$];

  logic [31:0] model_i = '0;
  logic [31:0] model_d = '0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory responder.
  logic        resp_ack   = 1'b0;
  logic [31:0] resp_rdata = '0;
  logic        manual_ack = 1'b0;
  bit          mem_mute   = 1'b0;
  int          ack_delay  = 0;

  assign bus.m_ack   = mem_mute ? manual_ack : resp_ack;
  assign bus.m_rdata = resp_rdata;

  initial begin
    mem_exp_t e;
    forever begin
      @(negedge clk);
      if (!mem_mute && bus.m_req === 1'b1) begin
        if (exp_mem.size() == 0) begin
          check("m_req_unexpected", bus.m_req, 1'b0);
        end else begin
          e = exp_mem.pop_front();
          check("m_we",   bus.m_we,   e.we);
          check("m_addr", bus.m_addr, e.addr);
          check("m_mask", bus.m_mask, e.mask);
          if (e.we) check("m_wdata", bus.m_wdata, e.wdata);
          for (int k = 0; k < ack_delay; k++) begin
            @(negedge clk);
            check("m_hold", {bus.m_req, bus.m_we, bus.m_addr, bus.m_mask},
                  {1'b1, e.we, e.addr, e.mask});
            if (e.we) check("m_wdata_hold", bus.m_wdata, e.wdata);
            check("busy_hold", busy, 1'b1);
          end
          resp_ack   = 1'b1;
          resp_rdata = e.rdata;
          @(negedge clk);
          resp_ack   = 1'b0;
          resp_rdata = ~e.rdata;
        end
      end
    end
  end

  task automatic push_i(input logic [31:0] addr, input logic [31:0] rdata);
    exp_mem.push_back('{we: 1'b0, addr: {addr[31:2], 2'b00}, mask: 4'hF,
                        wdata: 32'h0, rdata: rdata});
    model_i = rdata;
    exp_resp.push_back('{is_i: 1'b1, i_rdata: model_i, d_rdata: model_d});
  endtask

  task automatic push_d(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] wdata,
                        input logic [31:0] rdata);
    exp_mem.push_back('{we: wr, addr: {addr[31:2], 2'b00}, mask: (wr ? mask : 4'hF),
                        wdata: wdata, rdata: rdata});
    if (!wr) model_d = rdata;
    exp_resp.push_back('{is_i: 1'b0, i_rdata: model_i, d_rdata: model_d});
    dq.push_back('{rd: rd, wr: wr, addr: addr, mask: mask, wdata: wdata});
  endtask

  task automatic load_d();
    dreq_t r;
    if (dq.size() > 0) begin
      r       = dq.pop_front();
      d_rd    = r.rd;
      d_wr    = r.wr;
      d_addr  = r.addr;
      d_mask  = r.mask;
      d_wdata = r.wdata;
    end else begin
      d_rd = 1'b0;
      d_wr = 1'b0;
    end
  endtask

  // Acts as both requesters: drops or replaces a request after its valid,
  // and checks every completion against the expected queue.
  task automatic service(input int budget, output int first_lat);
    int        cyc;
    resp_exp_t r;
    cyc       = 0;
    first_lat = -1;
    while (exp_resp.size() > 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (i_valid || d_valid) begin
        if (first_lat < 0) first_lat = cyc;
        r = exp_resp.pop_front();
        check("valid_kind", {i_valid, d_valid}, r.is_i ? 2'b10 : 2'b01);
        check("i_rdata", i_rdata, r.i_rdata);
        check("d_rdata", d_rdata, r.d_rdata);
        if (i_valid) i_req = 1'b0;
        if (d_valid) load_d();
      end
    end
    check("completions_pending", exp_resp.size(), 0);
    exp_resp.delete();
    dq.delete();
    i_req = 1'b0;
    d_rd  = 1'b0;
    d_wr  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_extra_valid", {i_valid, d_valid}, 2'b00);
    end
    check("bus_txn_pending", exp_mem.size(), 0);
    exp_mem.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctrl"},    {bus.m_req, bus.m_we, busy, i_valid, d_valid}, 5'b0);
    check({tag, "_m_addr"},  bus.m_addr,  32'h0);
    check({tag, "_m_mask"},  bus.m_mask,  4'h0);
    check({tag, "_m_wdata"}, bus.m_wdata, 32'h0);
    check({tag, "_i_rdata"}, i_rdata,     32'h0);
    check({tag, "_d_rdata"}, d_rdata,     32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    reset   = 1'b1;
    i_req   = 1'b0;
    i_addr  = '0;
    d_rd    = 1'b0;
    d_wr    = 1'b0;
    d_addr  = '0;
    d_mask  = '0;
    d_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    reset = 1'b0;

    // Single fetch, minimum latency.
    @(negedge clk);
    push_i(32'h0000_0106, 32'hDEAD_BEEF);
    i_addr = 32'h0000_0106;
    i_req  = 1'b1;
    service(20, lat);
    check("fetch_latency", lat, 2);

    // Simultaneous fetch and load: data first.
    @(negedge clk);
    push_d(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 32'h1111_2222);
    push_i(32'h40, 32'h3333_4444);
    load_d();
    i_addr = 32'h40;
    i_req  = 1'b1;
    service(40, lat);

    // Starvation limit, twice in a row to show the counter restarts at 0.
    for (int round = 0; round < 2; round++) begin
      @(negedge clk);
      for (int k = 0; k < STARVE_LIMIT; k++)
        push_d(1'b1, 1'b0, 32'(32'h1000 + round * 256 + k * 4), 4'h0, 32'h0,
               32'(32'hA000_0000 + round * 16 + k));
      push_i(32'(32'h2000 + round * 4), 32'(32'hC0DE_0000 + round));
      push_d(1'b1, 1'b0, 32'(32'h1800 + round * 4), 4'h0, 32'h0,
             32'(32'hB000_0000 + round));
      load_d();
      i_addr = 32'(32'h2000 + round * 4);
      i_req  = 1'b1;
      service(200, lat);
    end

    // Store with d_rd also high; d_rdata must not change.
    @(negedge clk);
    push_d(1'b1, 1'b1, 32'h203, 4'b1000, 32'h5500_0000, 32'hFFFF_FFFF);
    load_d();
    service(20, lat);

    // Slow memory: five wait cycles.
    ack_delay = 5;
    @(negedge clk);
    push_d(1'b1, 1'b0, 32'h300, 4'h0, 32'h0, 32'h1234_5678);
    load_d();
    service(40, lat);
    check("slow_latency", lat, 7);
    ack_delay = 0;

    // Reset in BUSY_D with a late m_ack.
    mem_mute = 1'b1;
    @(negedge clk);
    d_rd   = 1'b1;
    d_addr = 32'h400;
    @(negedge clk);
    check("pre_reset_busy", {busy, bus.m_req, bus.m_we}, 3'b110);
    reset = 1'b1;
    d_rd  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    manual_ack = 1'b1;
    @(negedge clk);
    manual_ack = 1'b0;
    check_reset("late_ack");
    repeat (3) begin
      @(negedge clk);
      check_reset("after_abort");
    end
    mem_mute = 1'b0;
    model_i  = '0;
    model_d  = '0;

    // Normal operation resumes after the abort.
    @(negedge clk);
    push_i(32'h80, 32'h0BAD_F00D);
    i_addr = 32'h80;
    i_req  = 1'b1;
    service(20, lat);
    check("resume_latency", lat, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
